// File: rtl/tx_arbiter.sv
// Round-robin launcher that shares one 7-bit serial transmitter among N_REQ clients.
// After each launch it holds off all requesters for the frame time plus the idle gap.
module tx_arbiter #(
   parameter int N_REQ        = 4,
   parameter int FRAME_CYCLES = 10,
   parameter int GAP_CYCLES   = 1
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [N_REQ-1:0]         req,
   input  logic [7*N_REQ-1:0]       data_in,
   output logic [N_REQ-1:0]         ack,
   output logic                     tx_start,
   output logic [6:0]               tx_data,
   output logic                     busy,
   output logic [$clog2(N_REQ)-1:0] grant_idx,
   output logic [15:0]              frame_count
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int PW    = IDX_W + 1;
   localparam int DW    = 7;
   localparam int CNT_W = $clog2(FRAME_CYCLES + GAP_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_GAP    = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               tx_start_q, tx_start_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic [DW-1:0]      tx_data_q, tx_data_d;
   logic               busy_q, busy_d;
   logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
   logic [15:0]        frame_count_q, frame_count_d;

   logic [PW-1:0]      cand_s;
   logic [IDX_W-1:0]   win_idx_s;
   logic               win_found_s;

   // Round-robin winner search: grant_idx_q doubles as the pointer, so the search
   // starts just after the last grant; scanning downward lets the nearest hit win.
   always_comb begin
      cand_s      = '0;
      win_idx_s   = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         cand_s    = {1'b0, grant_idx_q} + PW'(k);
         cand_s    = (cand_s >= PW'(N_REQ)) ? (cand_s - PW'(N_REQ)) : cand_s;
         win_idx_s = req[cand_s[IDX_W-1:0]] ? cand_s[IDX_W-1:0] : win_idx_s;
      end
      win_found_s = |req;
   end

   // Next-state and next-output logic for the launch / wait / gap sequence.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      tx_start_d    = 1'b0;
      ack_d         = '0;
      tx_data_d     = tx_data_q;
      grant_idx_d   = grant_idx_q;
      frame_count_d = frame_count_q;
      case (state_q)
         ST_IDLE: begin
            if (win_found_s) begin
               state_d            = ST_LAUNCH;
               tx_start_d         = 1'b1;
               ack_d[win_idx_s]   = 1'b1;
               tx_data_d          = data_in[int'(win_idx_s) * DW +: DW];
               grant_idx_d        = win_idx_s;
               frame_count_d      = frame_count_q + 16'd1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         // WAIT spans FRAME_CYCLES-2 cycles so the next start lands exactly
         // FRAME_CYCLES+GAP_CYCLES after this one, counting the IDLE decision cycle.
         ST_LAUNCH: begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(FRAME_CYCLES - 3);
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               if (GAP_CYCLES > 0) begin
                  state_d = ST_GAP;
                  cnt_d   = CNT_W'(GAP_CYCLES - 1);
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         tx_start_q    <= 1'b0;
         ack_q         <= '0;
         tx_data_q     <= '0;
         busy_q        <= 1'b0;
         grant_idx_q   <= IDX_W'(N_REQ - 1);
         frame_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         tx_start_q    <= tx_start_d;
         ack_q         <= ack_d;
         tx_data_q     <= tx_data_d;
         busy_q        <= busy_d;
         grant_idx_q   <= grant_idx_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign ack         = ack_q;
   assign tx_start    = tx_start_q;
   assign tx_data     = tx_data_q;
   assign busy        = busy_q;
   assign grant_idx   = grant_idx_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter with a small transmitter stand-in driving a serial line.
module tb_tx_arbiter;

   localparam int N_REQ  = 4;
   localparam int FRAME  = 10;
   localparam int GAP    = 1;
   localparam int PERIOD = FRAME + GAP;

   logic              clk = 1'b0;
   logic              rstn;
   logic [N_REQ-1:0]  req;
   logic [7*N_REQ-1:0] data_in;
   logic [N_REQ-1:0]  ack;
   logic              tx_start;
   logic [6:0]        tx_data;
   logic              busy;
   logic [1:0]        grant_idx;
   logic [15:0]       frame_count;

   int n_checks = 0;
   int n_errors = 0;

   tx_arbiter #(.N_REQ(N_REQ), .FRAME_CYCLES(FRAME), .GAP_CYCLES(GAP)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req        (req),
      .data_in    (data_in),
      .ack        (ack),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .busy       (busy),
      .grant_idx  (grant_idx),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Transmitter stand-in: start, 7 data bits LSB first, even parity, idle high.
   int          tx_cnt = 0;
   logic [9:0]  tx_frame = 10'h3FF;
   logic        ser_line;

   always @(posedge clk) begin
      if (!rstn) begin
         tx_cnt <= 0;
      end else if (tx_start) begin
         check_eq("tx_overlap", 32'(tx_cnt > 1), 32'd0);
         tx_cnt   <= FRAME;
         tx_frame <= {1'b1, ^tx_data, tx_data, 1'b0};
      end else if (tx_cnt > 0) begin
         tx_cnt <= tx_cnt - 1;
      end
   end

   assign ser_line = (tx_cnt > 0) ? tx_frame[FRAME - tx_cnt] : 1'b1;

   // 0x55 -> start 0, data 1,0,1,0,1,0,1, parity 0, idle 1 (bit i = cycle i)
   logic [9:0] exp_line = 10'b1010101010;

   task automatic do_reset();
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic wait_start(output int ticks);
      ticks = 0;
      do begin
         @(negedge clk);
         ticks++;
      end while (!tx_start && ticks < 40);
      check_eq("start_seen", 32'(tx_start), 32'd1);
   endtask

   initial begin
      int ticks;
      int exp_idx;
      rstn    = 1'b0;
      req     = '0;
      data_in = '0;

      // Reset then idle
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_eq("idle_tx_start", 32'(tx_start), 32'd0);
         check_eq("idle_ack", 32'(ack), 32'd0);
         check_eq("idle_busy", 32'(busy), 32'd0);
      end
      check_eq("rst_grant_idx", 32'(grant_idx), 32'd3);
      check_eq("rst_frame_count", 32'(frame_count), 32'd0);
      check_eq("rst_tx_data", 32'(tx_data), 32'd0);

      // Single request from requester 2 with payload 0x55
      data_in[20:14] = 7'h55;
      req = 4'b0100;
      @(negedge clk);
      check_eq("single_tx_start", 32'(tx_start), 32'd1);
      check_eq("single_ack", 32'(ack), 32'h4);
      check_eq("single_tx_data", 32'(tx_data), 32'h55);
      check_eq("single_grant_idx", 32'(grant_idx), 32'd2);
      check_eq("single_frame_count", 32'(frame_count), 32'd1);
      check_eq("single_busy", 32'(busy), 32'd1);
      req = 4'b0000;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq($sformatf("ser_bit%0d", i), 32'(ser_line), 32'(exp_line[i]));
         if (i == 0) begin
            check_eq("single_start_drop", 32'(tx_start), 32'd0);
            check_eq("single_ack_drop", 32'(ack), 32'd0);
         end
         if (i == 8) check_eq("busy_last_cycle", 32'(busy), 32'd1);
         if (i == 9) begin
            check_eq("busy_fall", 32'(busy), 32'd0);
            check_eq("tx_data_held", 32'(tx_data), 32'h55);
         end
      end

      // All requesting: grants 0,1,2,3,0 spaced PERIOD apart
      do_reset();
      data_in = {7'h04, 7'h03, 7'h02, 7'h01};
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         wait_start(ticks);
         exp_idx = g % 4;
         check_eq($sformatf("rr_ack%0d", g), 32'(ack), 32'(1 << exp_idx));
         check_eq($sformatf("rr_data%0d", g), 32'(tx_data), 32'(exp_idx + 1));
         check_eq($sformatf("rr_idx%0d", g), 32'(grant_idx), 32'(exp_idx));
         check_eq($sformatf("rr_count%0d", g), 32'(frame_count), 32'(g + 1));
         if (g > 0) check_eq($sformatf("rr_spacing%0d", g), 32'(ticks), 32'(PERIOD));
      end
      req = 4'b0000;

      // Starvation: req[0] held, req[3] raised mid-frame wins the next launch
      do_reset();
      req = 4'b0001;
      wait_start(ticks);
      check_eq("starve_first_ack", 32'(ack), 32'h1);
      repeat (4) @(negedge clk);
      req = 4'b1001;
      wait_start(ticks);
      check_eq("starve_ack3", 32'(ack), 32'h8);
      check_eq("starve_idx3", 32'(grant_idx), 32'd3);
      check_eq("starve_spacing", 32'(ticks), 32'(PERIOD - 4));
      req = 4'b0001;
      wait_start(ticks);
      check_eq("starve_ack0", 32'(ack), 32'h1);
      check_eq("starve_spacing0", 32'(ticks), 32'(PERIOD));

      // Reset mid-frame, then relaunch one cycle after release
      do_reset();
      req = 4'b0010;
      wait_start(ticks);
      check_eq("midrst_ack", 32'(ack), 32'h2);
      repeat (4) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      check_eq("midrst_busy", 32'(busy), 32'd0);
      check_eq("midrst_count", 32'(frame_count), 32'd0);
      check_eq("midrst_tx_start", 32'(tx_start), 32'd0);
      check_eq("midrst_idx", 32'(grant_idx), 32'd3);
      rstn = 1'b1;
      @(negedge clk);
      check_eq("relaunch_tx_start", 32'(tx_start), 32'd1);
      check_eq("relaunch_ack", 32'(ack), 32'h2);
      check_eq("relaunch_count", 32'(frame_count), 32'd1);
      req = 4'b0000;

      // Frame counter wrap
      repeat (PERIOD + 1) @(negedge clk);
      check_eq("wrap_idle", 32'(busy), 32'd0);
      force dut.frame_count_q = 16'hFFFF;
      @(negedge clk);
      release dut.frame_count_q;
      check_eq("wrap_preload", 32'(frame_count), 32'hFFFF);
      req = 4'b0001;
      @(negedge clk);
      check_eq("wrap_tx_start", 32'(tx_start), 32'd1);
      check_eq("wrap_count", 32'(frame_count), 32'd0);
      req = 4'b0000;
      repeat (PERIOD + 1) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
